// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit (SLL, SRL, SRA, ROL, ROR).
// Shifts at most STEP bit positions per clock under a start/busy/done
// handshake and reports z/v/n flags with the same meaning as the ALU.
// An illegal op completes in one cycle, returns a unchanged and raises err.
module seq_shifter #(
   parameter int WIDTH = 16,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             z,
   output logic             v,
   output logic             n,
   output logic             err
);

   // Remaining-count width: must be able to hold the value WIDTH itself.
   localparam int LW = $clog2(WIDTH);
   localparam int CW = LW + 1;

   localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
   localparam logic [CW-1:0]    STEP_C  = CW'(STEP);
   localparam logic [WIDTH-1:0] WIDTH_B = WIDTH'(WIDTH);

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] data_reg;
   logic [CW-1:0]    rem_reg;
   logic [2:0]       op_reg;
   logic             sign_reg;
   logic             v_acc_reg;

   logic [CW-1:0]    k_amt;
   logic             op_legal;
   logic [CW-1:0]    step_amt;
   logic [WIDTH-1:0] shift_next;
   logic             lost_bit;
   logic             reg_legal;

   // Effective amount: shifts saturate at WIDTH, rotates wrap modulo WIDTH.
   always_comb begin
      k_amt    = '0;
      op_legal = (op <= OP_ROR);
      if (op == OP_ROL || op == OP_ROR) begin
         k_amt = {1'b0, b[LW-1:0]};
      end else if (b >= WIDTH_B) begin
         k_amt = WIDTH_C;
      end else begin
         k_amt = b[CW-1:0];
      end
   end

   // One step of the datapath: move by min(STEP, remaining) positions.
   always_comb begin
      step_amt   = (rem_reg > STEP_C) ? STEP_C : rem_reg;
      shift_next = data_reg;
      case (op_reg)
         OP_SLL:  shift_next = data_reg << step_amt;
         OP_SRL:  shift_next = data_reg >> step_amt;
         OP_SRA:  shift_next = $unsigned($signed(data_reg) >>> step_amt);
         OP_ROL:  shift_next = (data_reg << step_amt) | (data_reg >> (WIDTH_C - step_amt));
         OP_ROR:  shift_next = (data_reg >> step_amt) | (data_reg << (WIDTH_C - step_amt));
         default: shift_next = data_reg;
      endcase
   end

   // SLL overflow detect: any bit leaving the top this step that differs
   // from the original sign bit means the arithmetic value is lost.
   always_comb begin
      lost_bit = 1'b0;
      for (int i = 0; i < STEP; i++) begin
         if ((CW'(i) < step_amt) && (data_reg[WIDTH-1-i] != sign_reg)) begin
            lost_bit = 1'b1;
         end
      end
   end

   // Legality of the captured op, used when the result is committed.
   always_comb begin
      reg_legal = (op_reg <= OP_ROR);
   end

   // Control FSM with registered outputs: capture, step, then commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         data_reg  <= '0;
         rem_reg   <= '0;
         op_reg    <= '0;
         sign_reg  <= 1'b0;
         v_acc_reg <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         z         <= 1'b0;
         v         <= 1'b0;
         n         <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  data_reg  <= a;
                  op_reg    <= op;
                  sign_reg  <= a[WIDTH-1];
                  v_acc_reg <= 1'b0;
                  // Illegal ops skip shifting and commit on the next edge.
                  rem_reg   <= op_legal ? k_amt : '0;
                  busy      <= 1'b1;
                  state_reg <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (rem_reg == '0) begin
                  result    <= data_reg;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  err       <= !reg_legal;
                  z         <= reg_legal && (data_reg == '0);
                  n         <= (op_reg == OP_SRA) && data_reg[WIDTH-1];
                  // Final MSB must also match the original sign for SLL.
                  v         <= (op_reg == OP_SLL) &&
                               (v_acc_reg || (data_reg[WIDTH-1] != sign_reg));
                  state_reg <= S_IDLE;
               end else begin
                  data_reg <= shift_next;
                  rem_reg  <= rem_reg - step_amt;
                  if (op_reg == OP_SLL && lost_bit) begin
                     v_acc_reg <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg <= S_IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed and randomized checks of seq_shifter against a
// behavioural model computed directly from the shift/rotate rules.
module tb_seq_shifter;

   localparam int W = 16;
   localparam int S = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          z;
   logic          v;
   logic          n;
   logic          err;

   int checks = 0;
   int errors = 0;

   seq_shifter #(.WIDTH(W), .STEP(S)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .z      (z),
      .v      (v),
      .n      (n),
      .err    (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: whole-amount arithmetic on the original operand.
   task automatic model(input logic [2:0] m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                        output logic [W-1:0] m_res, output logic m_z, output logic m_v,
                        output logic m_n, output logic m_err, output int m_lat);
      int k;
      logic signed [W-1:0] sa;
      logic [2*W-1:0] dbl;
      k     = 0;
      m_v   = 1'b0;
      m_n   = 1'b0;
      m_err = 1'b0;
      sa    = m_a;
      dbl   = {m_a, m_a};
      if (m_op > 3'd4) begin
         m_res = m_a;
         m_err = 1'b1;
         m_z   = 1'b0;
         m_lat = 1;
      end else begin
         if (m_op == 3'd3 || m_op == 3'd4) k = int'(m_b) % W;
         else k = (int'(m_b) > W) ? W : int'(m_b);
         case (m_op)
            3'd0: m_res = (k >= W) ? '0 : (m_a << k);
            3'd1: m_res = (k >= W) ? '0 : (m_a >> k);
            3'd2: m_res = $unsigned(sa >>> k);
            3'd3: m_res = W'(dbl >> (W - k));
            default: m_res = W'(dbl >> k);
         endcase
         if (m_op == 3'd0) begin
            for (int i = 0; i < k; i++) if (m_a[W-1-i] != m_a[W-1]) m_v = 1'b1;
            if (m_res[W-1] != m_a[W-1]) m_v = 1'b1;
         end
         if (m_op == 3'd2) m_n = m_res[W-1];
         m_z   = (m_res == '0);
         m_lat = 1 + (k + S - 1) / S;
      end
   endtask

   // Present a request; when b2b is set we are already inside a done cycle.
   task automatic issue(input bit b2b, input logic [2:0] i_op, input logic [W-1:0] i_a,
                        input logic [W-1:0] i_b);
      if (!b2b) @(negedge clk);
      start = 1'b1;
      op    = i_op;
      a     = i_a;
      b     = i_b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
   endtask

   // Count edges until done, bounded so a stuck DUT cannot hang the run.
   task automatic wait_done(output int lat, output bit timeout);
      lat     = 0;
      timeout = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, result, z, v, n, err} !== '0) begin
         errors++;
         $display("FAIL reset_state got=%h need=0", {busy, done, result, z, v, n, err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      $display("txn reset released");
   endtask

   task automatic test_directed;
      logic [2:0]   t_op  [10] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd6};
      logic [W-1:0] t_a   [10] = '{16'hAA00, 16'h00FF, 16'hFFFF, 16'h8000, 16'h8000,
                                   16'h8001, 16'h0001, 16'h4000, 16'h0001, 16'h1234};
      logic [W-1:0] t_b   [10] = '{16'd4, 16'd8, 16'd0, 16'd15, 16'd20, 16'd17, 16'd4,
                                   16'd1, 16'd16, 16'd0};
      logic [W-1:0] t_res [10] = '{16'h0AA0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                   16'h0003, 16'h1000, 16'h8000, 16'h0000, 16'h1234};
      int           t_lat [10] = '{2, 3, 1, 5, 5, 2, 2, 2, 5, 1};
      logic [W-1:0] m_res;
      logic m_z, m_v, m_n, m_err;
      int m_lat, lat;
      bit to;
      for (int i = 0; i < 10; i++) begin
         model(t_op[i], t_a[i], t_b[i], m_res, m_z, m_v, m_n, m_err, m_lat);
         issue(1'b0, t_op[i], t_a[i], t_b[i]);
         wait_done(lat, to);
         $display("txn directed op=%0d a=%h b=%0d result=%h z=%b v=%b n=%b err=%b lat=%0d",
                  t_op[i], t_a[i], t_b[i], result, z, v, n, err, lat);
         checks++;
         if (to || lat != t_lat[i]) begin
            errors++;
            $display("FAIL directed_latency[%0d] got=%0d need=%0d", i, lat, t_lat[i]);
         end
         checks++;
         if (result !== t_res[i]) begin
            errors++;
            $display("FAIL directed_result[%0d] got=%h need=%h", i, result, t_res[i]);
         end
         checks++;
         if ({z, v, n, err, busy} !== {m_z, m_v, m_n, m_err, 1'b0}) begin
            errors++;
            $display("FAIL directed_flags[%0d] got zvne_busy=%b need=%b", i,
                     {z, v, n, err, busy}, {m_z, m_v, m_n, m_err, 1'b0});
         end
         @(posedge clk);
         #1;
         checks++;
         if (done !== 1'b0 || result !== t_res[i]) begin
            errors++;
            $display("FAIL directed_hold[%0d] got done=%b result=%h need done=0 result=%h",
                     i, done, result, t_res[i]);
         end
      end
   endtask

   task automatic test_random;
      logic [2:0]   r_op;
      logic [W-1:0] r_a, r_b, m_res;
      logic m_z, m_v, m_n, m_err;
      int m_lat, lat;
      bit to;
      for (int i = 0; i < 80; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = W'($urandom);
         r_b  = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 20));
         model(r_op, r_a, r_b, m_res, m_z, m_v, m_n, m_err, m_lat);
         issue(1'b0, r_op, r_a, r_b);
         wait_done(lat, to);
         $display("txn random op=%0d a=%h b=%h result=%h z=%b v=%b n=%b err=%b lat=%0d",
                  r_op, r_a, r_b, result, z, v, n, err, lat);
         checks++;
         if (to || lat != m_lat) begin
            errors++;
            $display("FAIL random_latency[%0d] got=%0d need=%0d", i, lat, m_lat);
         end
         checks++;
         if ({result, z, v, n, err} !== {m_res, m_z, m_v, m_n, m_err}) begin
            errors++;
            $display("FAIL random_result[%0d] got res=%h zvne=%b need res=%h zvne=%b", i,
                     result, {z, v, n, err}, m_res, {m_z, m_v, m_n, m_err});
         end
      end
   endtask

   task automatic test_busy_ignore;
      int lat;
      bit to;
      issue(1'b0, 3'd2, 16'h8000, 16'd15);
      @(posedge clk);
      #1;
      start = 1'b1;
      op    = 3'd0;
      a     = 16'h0001;
      b     = 16'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, to);
      $display("txn busy_ignore result=%h n=%b lat=%0d", result, n, lat + 2);
      checks++;
      if (to || lat + 2 != 5 || result !== 16'hFFFF || n !== 1'b1) begin
         errors++;
         $display("FAIL busy_ignore got lat=%0d res=%h n=%b need lat=5 res=ffff n=1",
                  lat + 2, result, n);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore_no_queue got busy=%b done=%b need 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      bit to;
      issue(1'b0, 3'd1, 16'hAA00, 16'd4);
      wait_done(lat, to);
      // Still inside the done cycle: launch the next op right away.
      issue(1'b1, 3'd3, 16'h8001, 16'd17);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept got done=%b busy=%b need done=0 busy=1", done, busy);
      end
      wait_done(lat, to);
      $display("txn back_to_back result=%h lat=%0d", result, lat);
      checks++;
      if (to || lat != 2 || result !== 16'h0003 || err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_result got lat=%0d res=%h err=%b need lat=2 res=0003 err=0",
                  lat, result, err);
      end
   endtask

   task automatic test_illegal_then_legal;
      int lat;
      bit to;
      issue(1'b0, 3'd7, 16'hBEEF, 16'd9);
      wait_done(lat, to);
      checks++;
      if (to || lat != 1 || result !== 16'hBEEF || {z, v, n, err} !== 4'b0001) begin
         errors++;
         $display("FAIL illegal got lat=%0d res=%h zvne=%b need lat=1 res=beef zvne=0001",
                  lat, result, {z, v, n, err});
      end
      issue(1'b0, 3'd4, 16'h0001, 16'd4);
      wait_done(lat, to);
      $display("txn illegal_then_legal result=%h err=%b", result, err);
      checks++;
      if (err !== 1'b0 || result !== 16'h1000) begin
         errors++;
         $display("FAIL legal_clears_err got err=%b res=%h need err=0 res=1000", err, result);
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      bit to;
      bit saw_done;
      issue(1'b0, 3'd6, 16'h1234, 16'd0);
      wait_done(lat, to);
      issue(1'b0, 3'd0, 16'hFFFF, 16'd16);
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, z, v, n, err} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs got=%h need=0", {busy, done, result, z, v, n, err});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      saw_done = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done || busy) saw_done = 1'b1;
      end
      $display("txn reset_mid saw_activity=%b", saw_done);
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL reset_mid_abort got activity=1 need 0");
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_busy_ignore;
      test_back_to_back;
      test_illegal_then_legal;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
